// File: rtl/perspective_projection.sv
// rtl/perspective_projection.sv - perspective divide of a transformed vertex to clipped screen coordinates
// Two sequential 32-cycle restoring divides (x then y) share one divider datapath.
module perspective_projection #(
  parameter int FOCAL    = 256,
  parameter int Z_OFFSET = 512,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_sx,
  output logic [8:0]  out_sy,
  output logic        out_clip
);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  localparam logic signed [31:0] FOCAL_S  = 32'(FOCAL);
  localparam logic signed [17:0] Z_OFF_S  = 18'(Z_OFFSET);
  localparam logic signed [32:0] HALF_W   = 33'(SCREEN_W / 2);
  localparam logic signed [32:0] HALF_H   = 33'(SCREEN_H / 2);
  localparam logic signed [32:0] MAX_X    = 33'(SCREEN_W - 1);
  localparam logic signed [32:0] MAX_Y    = 33'(SCREEN_H - 1);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [17:0]        d_q, d_d;
  logic               neg_x_q, neg_x_d;
  logic               neg_y_q, neg_y_d;
  logic [31:0]        ny_abs_q, ny_abs_d;
  logic [31:0]        quo_q, quo_d;
  logic [18:0]        rem_q, rem_d;
  logic signed [31:0] qx_q, qx_d;
  logic [9:0]         out_sx_q, out_sx_d;
  logic [8:0]         out_sy_q, out_sy_d;
  logic               out_clip_q, out_clip_d;

  logic signed [31:0] x_ext, y_ext, nx, ny;
  logic [31:0]        nx_abs, ny_abs;
  logic signed [17:0] d_calc;
  logic [18:0]        rem_sh, d_ext, rem_nx;
  logic [31:0]        quo_nx;
  logic               ge;
  logic               neg_cur;
  logic signed [31:0] q_mag, q_signed;
  logic signed [32:0] sx_full, sy_full, sx_sat, sy_sat;
  logic               clip_x, clip_y;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign out_sx    = out_sx_q;
  assign out_sy    = out_sy_q;
  assign out_clip  = out_clip_q;

  always_comb begin
    x_ext  = 32'(signed'(in_x));
    y_ext  = 32'(signed'(in_y));
    nx     = x_ext * FOCAL_S;
    ny     = y_ext * FOCAL_S;
    nx_abs = nx[31] ? 32'(-nx) : nx;
    ny_abs = ny[31] ? 32'(-ny) : ny;
    d_calc = 18'(signed'(in_z)) + Z_OFF_S;
  end

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q[17:0], quo_q[31]};
    d_ext  = {1'b0, d_q};
    ge     = rem_q[18] | (rem_sh >= d_ext);
    rem_nx = ge ? (rem_sh - d_ext) : rem_sh;
    quo_nx = {quo_q[30:0], ge};
    neg_cur  = (state_q == DIV_Y) ? neg_y_q : neg_x_q;
    q_mag    = quo_nx;
    q_signed = neg_cur ? -q_mag : q_mag;
  end

  always_comb begin
    sx_full = HALF_W + 33'(qx_q);
    sy_full = HALF_H - 33'(q_signed);
    clip_x  = 1'b1;
    clip_y  = 1'b1;
    if (sx_full < 0)          sx_sat = '0;
    else if (sx_full > MAX_X) sx_sat = MAX_X;
    else begin
      sx_sat = sx_full;
      clip_x = 1'b0;
    end
    if (sy_full < 0)          sy_sat = '0;
    else if (sy_full > MAX_Y) sy_sat = MAX_Y;
    else begin
      sy_sat = sy_full;
      clip_y = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_d        = d_q;
    neg_x_d    = neg_x_q;
    neg_y_d    = neg_y_q;
    ny_abs_d   = ny_abs_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    qx_d       = qx_q;
    out_sx_d   = out_sx_q;
    out_sy_d   = out_sy_q;
    out_clip_d = out_clip_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (d_calc <= 0) begin
            state_d    = DONE;
            out_sx_d   = '0;
            out_sy_d   = '0;
            out_clip_d = 1'b1;
          end else begin
            state_d  = DIV_X;
            d_d      = d_calc;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = nx_abs;
            neg_x_d  = nx[31];
            neg_y_d  = ny[31];
            ny_abs_d = ny_abs;
          end
        end
      end
      DIV_X: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DIV_Y;
          qx_d    = q_signed;
          rem_d   = '0;
          quo_d   = ny_abs_q;
        end
      end
      DIV_Y: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d    = DONE;
          out_sx_d   = sx_sat[9:0];
          out_sy_d   = sy_sat[8:0];
          out_clip_d = clip_x | clip_y;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      d_q        <= '0;
      neg_x_q    <= 1'b0;
      neg_y_q    <= 1'b0;
      ny_abs_q   <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      qx_q       <= '0;
      out_sx_q   <= '0;
      out_sy_q   <= '0;
      out_clip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      neg_x_q    <= neg_x_d;
      neg_y_q    <= neg_y_d;
      ny_abs_q   <= ny_abs_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      qx_q       <= qx_d;
      out_sx_q   <= out_sx_d;
      out_sy_q   <= out_sy_d;
      out_clip_q <= out_clip_d;
    end
  end

endmodule
